tlul_to_reg: RTL and testbench

- TL-UL device-side responder that converts single-beat TL-UL A-channel requests into register-interface transactions and returns D-channel responses.
- Sits between a TL-UL crossbar/host port and register-interface peripherals. It is the counterpart of the register-to-TL-UL host bridge.
- One transaction in flight at a time, fully registered toward both sides.

---
 rtl/tlul_reg_pkg.sv | 99 +++++++++
 rtl/tlul_to_reg.sv | 121 ++++++++++++
 tb/tb_tlul_to_reg.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tlul_reg_pkg.sv
// Shared types, encodings and the A-channel legality check for the TL-UL to
// register-interface responder.
package tlul_reg_pkg;

    localparam int TL_AW    = 32;
    localparam int TL_DW    = 32;
    localparam int TL_SW    = TL_DW / 8;
    localparam int TL_LW    = $clog2(TL_SW);
    localparam int TL_SZW   = 2;
    localparam int TL_AIW   = 8;
    localparam int TL_DIW   = 1;
    localparam int TL_UW    = 8;
    localparam int TL_MAX_SIZE = TL_LW;

    localparam logic [TL_UW-1:0] TL_D_USER_DEFAULT = '0;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } state_e;

    typedef struct packed {
        logic               valid;
        logic               write;
        logic [TL_AW-1:0]   addr;
        logic [TL_DW-1:0]   wdata;
        logic [TL_SW-1:0]   wstrb;
    } reg_req_t;

    typedef struct packed {
        logic               ready;
        logic [TL_DW-1:0]   rdata;
        logic               error;
    } reg_rsp_t;

    typedef struct packed {
        logic               a_valid;
        logic [2:0]         a_opcode;
        logic [2:0]         a_param;
        logic [TL_SZW-1:0]  a_size;
        logic [TL_AIW-1:0]  a_source;
        logic [TL_AW-1:0]   a_address;
        logic [TL_SW-1:0]   a_mask;
        logic [TL_DW-1:0]   a_data;
        logic [TL_UW-1:0]   a_user;
        logic               d_ready;
    } tlul_h2d_t;

    typedef struct packed {
        logic               d_valid;
        logic [2:0]         d_opcode;
        logic [2:0]         d_param;
        logic [TL_SZW-1:0]  d_size;
        logic [TL_AIW-1:0]  d_source;
        logic [TL_DIW-1:0]  d_sink;
        logic [TL_DW-1:0]   d_data;
        logic [TL_UW-1:0]   d_user;
        logic               d_error;
        logic               a_ready;
    } tlul_d2h_t;

    // A lane belongs to the access when it falls in the same size-aligned block as the address.
    function automatic logic [TL_SW-1:0] tl_full_mask(input logic [TL_SZW-1:0] size,
                                                      input logic [TL_AW-1:0]  addr);
        logic [TL_SW-1:0] m;
        int               lane;
        m    = '0;
        lane = int'(addr[TL_LW-1:0]);
        for (int i = 0; i < TL_SW; i++) begin
            if ((i >> size) == (lane >> size)) m[i] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic tl_a_legal(input logic [2:0]        op,
                                        input logic [TL_SZW-1:0] size,
                                        input logic [TL_AW-1:0]  addr,
                                        input logic [TL_SW-1:0]  mask);
        logic ok;
        ok = (op == Get) || (op == PutFullData) || (op == PutPartialData);
        if (int'(size) > TL_MAX_SIZE) ok = 1'b0;
        if ((int'(addr[TL_LW-1:0]) & ((1 << size) - 1)) != 0) ok = 1'b0;
        if ((op == PutFullData) && (mask != tl_full_mask(size, addr))) ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/tlul_to_reg.sv
// TL-UL device responder: turns single-beat A requests into register-bus accesses.
// Latency: A accept -> reg valid +1 cycle -> d_valid +1 after reg ready; illegal requests answer in 1.
// Backpressure: a_ready only in IDLE; reg request held until ready, D response held until d_ready.
module tlul_to_reg
    import tlul_reg_pkg::*;
#(
    parameter type req_t    = reg_req_t,
    parameter type rsp_t    = reg_rsp_t,
    parameter type tl_h2d_t = tlul_h2d_t,
    parameter type tl_d2h_t = tlul_d2h_t,
    parameter int  AW       = TL_AW,
    parameter int  DW       = TL_DW
) (
    input  logic    clk_i,
    input  logic    rst_ni,
    input  tl_h2d_t tl_i,
    output tl_d2h_t tl_o,
    output req_t    reg_req_o,
    input  rsp_t    reg_rsp_i
);

    state_e             r_state;
    state_e             w_state_nxt;

    logic [2:0]         r_opcode;
    logic [AW-1:0]      r_addr;
    logic [DW-1:0]      r_wdata;
    logic [DW/8-1:0]    r_mask;
    logic [TL_AIW-1:0]  r_source;
    logic [TL_SZW-1:0]  r_size;
    logic [DW-1:0]      r_rdata;
    logic               r_err;

    logic               w_a_legal;
    logic               w_accept;
    logic               w_reg_done;
    logic               w_d_done;
    logic               w_is_get;
    logic               w_unused;

    assign w_a_legal  = tl_a_legal(tl_i.a_opcode, tl_i.a_size, tl_i.a_address, tl_i.a_mask);
    assign w_accept   = (r_state == IDLE) && tl_i.a_valid;
    assign w_reg_done = (r_state == REQ) && reg_rsp_i.ready;
    assign w_d_done   = (r_state == RSP) && tl_i.d_ready;
    assign w_is_get   = (r_opcode == Get);
    assign w_unused   = ^{tl_i.a_param, tl_i.a_user};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept)   w_state_nxt = w_a_legal ? REQ : RSP;
            REQ:     if (w_reg_done) w_state_nxt = RSP;
            RSP:     if (w_d_done)   w_state_nxt = IDLE;
            default:                 w_state_nxt = IDLE;
        endcase
    end

    // Illegal requests skip the register bus, so their error/zero-data response is set at capture.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_opcode <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_mask   <= '0;
            r_source <= '0;
            r_size   <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else if (w_accept) begin
            r_opcode <= tl_i.a_opcode;
            r_addr   <= tl_i.a_address;
            r_wdata  <= tl_i.a_data;
            r_mask   <= tl_i.a_mask;
            r_source <= tl_i.a_source;
            r_size   <= tl_i.a_size;
            r_rdata  <= '0;
            r_err    <= !w_a_legal;
        end else if (w_reg_done) begin
            r_rdata  <= w_is_get ? reg_rsp_i.rdata : '0;
            r_err    <= reg_rsp_i.error;
        end
    end

    always_comb begin
        tl_o        = '0;
        reg_req_o   = '0;
        tl_o.d_user = TL_D_USER_DEFAULT;
        case (r_state)
            IDLE: begin
                tl_o.a_ready = 1'b1;
            end
            REQ: begin
                reg_req_o.valid = 1'b1;
                reg_req_o.write = !w_is_get;
                reg_req_o.addr  = r_addr;
                reg_req_o.wdata = r_wdata;
                reg_req_o.wstrb = w_is_get ? '0 : r_mask;
            end
            RSP: begin
                tl_o.d_valid  = 1'b1;
                tl_o.d_opcode = w_is_get ? AccessAckData : AccessAck;
                tl_o.d_size   = r_size;
                tl_o.d_source = r_source;
                tl_o.d_data   = r_rdata;
                tl_o.d_error  = r_err;
            end
            default: begin
                tl_o.a_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_tlul_to_reg.sv
// Directed bench for tlul_to_reg: each task drives one scenario and checks
// hand-computed expectations on the D channel and register request.
module tb_tlul_to_reg;
    import tlul_reg_pkg::*;

    logic      clk = 1'b0;
    logic      rst_n;
    tlul_h2d_t tl_i;
    tlul_d2h_t tl_o;
    reg_req_t  reg_req;
    reg_rsp_t  reg_rsp;

    int n_cmp  = 0;
    int n_fail = 0;

    tlul_to_reg dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .tl_i      (tl_i),
        .tl_o      (tl_o),
        .reg_req_o (reg_req),
        .reg_rsp_i (reg_rsp)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic [2:0] op, input logic [31:0] addr, input logic [1:0] size,
                           input logic [3:0] mask, input logic [31:0] data, input logic [7:0] src);
        tl_i.a_valid   = 1'b1;
        tl_i.a_opcode  = op;
        tl_i.a_address = addr;
        tl_i.a_size    = size;
        tl_i.a_mask    = mask;
        tl_i.a_data    = data;
        tl_i.a_source  = src;
        tick();
        tl_i.a_valid   = 1'b0;
    endtask

    task automatic d_handshake();
        tl_i.d_ready = 1'b1;
        tick();
        tl_i.d_ready = 1'b0;
    endtask

    task automatic test_reset();
        tl_i    = '0;
        reg_rsp = '0;
        rst_n   = 1'b0;
        #22;
        n_cmp++; if (tl_o.a_ready !== 1'b1) begin n_fail++; $display("FAIL rst_a_ready got %b want 1", tl_o.a_ready); end
        n_cmp++; if (tl_o.d_valid !== 1'b0) begin n_fail++; $display("FAIL rst_d_valid got %b want 0", tl_o.d_valid); end
        n_cmp++; if (reg_req.valid !== 1'b0) begin n_fail++; $display("FAIL rst_reg_valid got %b want 0", reg_req.valid); end
        n_cmp++; if ({tl_o.d_data, tl_o.d_error, tl_o.d_opcode, tl_o.d_source, tl_o.d_size} !== '0) begin
            n_fail++; $display("FAIL rst_d_fields got data=%h err=%b op=%h src=%h size=%h want all 0",
                               tl_o.d_data, tl_o.d_error, tl_o.d_opcode, tl_o.d_source, tl_o.d_size);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_get();
        reg_rsp = '0;
        drive_a(3'd4, 32'h10, 2'd2, 4'hF, 32'h0, 8'h05);
        n_cmp++; if (reg_req.valid !== 1'b1) begin n_fail++; $display("FAIL get_reg_valid got %b want 1", reg_req.valid); end
        n_cmp++; if (reg_req.write !== 1'b0) begin n_fail++; $display("FAIL get_reg_write got %b want 0", reg_req.write); end
        n_cmp++; if (reg_req.addr !== 32'h10) begin n_fail++; $display("FAIL get_reg_addr got %h want 10", reg_req.addr); end
        n_cmp++; if (reg_req.wstrb !== 4'h0) begin n_fail++; $display("FAIL get_reg_wstrb got %h want 0", reg_req.wstrb); end
        n_cmp++; if (tl_o.a_ready !== 1'b0) begin n_fail++; $display("FAIL get_a_ready_req got %b want 0", tl_o.a_ready); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if ({reg_req.valid, reg_req.addr, tl_o.d_valid} !== {1'b1, 32'h10, 1'b0}) begin
                n_fail++; $display("FAIL get_req_hold cyc %0d got v=%b a=%h dv=%b want 1/10/0", i, reg_req.valid, reg_req.addr, tl_o.d_valid);
            end
        end
        reg_rsp.ready = 1'b1;
        reg_rsp.rdata = 32'hDEADBEEF;
        tick();
        reg_rsp = '0;
        n_cmp++; if (tl_o.d_valid !== 1'b1) begin n_fail++; $display("FAIL get_d_valid got %b want 1", tl_o.d_valid); end
        n_cmp++; if (tl_o.d_opcode !== 3'd1) begin n_fail++; $display("FAIL get_d_opcode got %h want 1", tl_o.d_opcode); end
        n_cmp++; if (tl_o.d_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL get_d_data got %h want deadbeef", tl_o.d_data); end
        n_cmp++; if (tl_o.d_error !== 1'b0) begin n_fail++; $display("FAIL get_d_error got %b want 0", tl_o.d_error); end
        n_cmp++; if ({tl_o.d_source, tl_o.d_size} !== {8'h05, 2'd2}) begin
            n_fail++; $display("FAIL get_d_echo got src=%h size=%h want 05/2", tl_o.d_source, tl_o.d_size);
        end
        n_cmp++; if (reg_req.valid !== 1'b0) begin n_fail++; $display("FAIL get_reg_drop got %b want 0", reg_req.valid); end
        d_handshake();
        n_cmp++; if ({tl_o.d_valid, tl_o.a_ready} !== 2'b01) begin
            n_fail++; $display("FAIL get_after_ack got dv=%b ar=%b want 0/1", tl_o.d_valid, tl_o.a_ready);
        end
    endtask

    task automatic test_put_partial();
        reg_rsp.ready = 1'b1;
        reg_rsp.rdata = 32'h12345678;
        drive_a(3'd1, 32'h4, 2'd2, 4'b0110, 32'h00AABB00, 8'h03);
        n_cmp++; if ({reg_req.valid, reg_req.write, reg_req.addr} !== {1'b1, 1'b1, 32'h4}) begin
            n_fail++; $display("FAIL pp_req got v=%b w=%b a=%h want 1/1/4", reg_req.valid, reg_req.write, reg_req.addr);
        end
        n_cmp++; if (reg_req.wstrb !== 4'b0110) begin n_fail++; $display("FAIL pp_wstrb got %b want 0110", reg_req.wstrb); end
        n_cmp++; if (reg_req.wdata !== 32'h00AABB00) begin n_fail++; $display("FAIL pp_wdata got %h want 00aabb00", reg_req.wdata); end
        tick();
        reg_rsp = '0;
        n_cmp++; if ({tl_o.d_valid, tl_o.d_opcode} !== {1'b1, 3'd0}) begin
            n_fail++; $display("FAIL pp_d_ack got dv=%b op=%h want 1/0", tl_o.d_valid, tl_o.d_opcode);
        end
        n_cmp++; if (tl_o.d_data !== 32'h0) begin n_fail++; $display("FAIL pp_d_data got %h want 0", tl_o.d_data); end
        n_cmp++; if ({tl_o.d_error, tl_o.d_source} !== {1'b0, 8'h03}) begin
            n_fail++; $display("FAIL pp_d_err_src got err=%b src=%h want 0/03", tl_o.d_error, tl_o.d_source);
        end
        d_handshake();
    endtask

    task automatic test_misaligned();
        reg_rsp.ready = 1'b1;
        drive_a(3'd4, 32'h2, 2'd2, 4'hF, 32'h0, 8'h07);
        n_cmp++; if (reg_req.valid !== 1'b0) begin n_fail++; $display("FAIL mis_reg_valid got %b want 0", reg_req.valid); end
        n_cmp++; if ({tl_o.d_valid, tl_o.d_error} !== 2'b11) begin
            n_fail++; $display("FAIL mis_d got dv=%b err=%b want 1/1", tl_o.d_valid, tl_o.d_error);
        end
        n_cmp++; if ({tl_o.d_data, tl_o.d_opcode, tl_o.d_source} !== {32'h0, 3'd1, 8'h07}) begin
            n_fail++; $display("FAIL mis_d_fields got data=%h op=%h src=%h want 0/1/07", tl_o.d_data, tl_o.d_opcode, tl_o.d_source);
        end
        d_handshake();
        reg_rsp = '0;
    endtask

    task automatic test_legality();
        // op, addr, size, mask, expected legal
        logic [2:0]  ops   [6] = '{3'd2,  3'd0,  3'd4,  3'd4,  3'd0,    3'd0};
        logic [31:0] addrs [6] = '{32'h0, 32'h0, 32'h0, 32'h1, 32'h2,   32'h3};
        logic [1:0]  sizes [6] = '{2'd2,  2'd2,  2'd3,  2'd1,  2'd1,    2'd0};
        logic [3:0]  masks [6] = '{4'hF,  4'h7,  4'hF,  4'h3,  4'b1100, 4'b1000};
        logic        legal [6] = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b1,    1'b1};
        reg_rsp.ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive_a(ops[i], addrs[i], sizes[i], masks[i], 32'h0, 8'(i));
            n_cmp++; if ({reg_req.valid, tl_o.d_valid} !== {legal[i], !legal[i]}) begin
                n_fail++; $display("FAIL legal_%0d got reg_v=%b dv=%b want %b/%b", i, reg_req.valid, tl_o.d_valid, legal[i], !legal[i]);
            end
            if (legal[i]) tick();
            n_cmp++; if ({tl_o.d_valid, tl_o.d_error} !== {1'b1, !legal[i]}) begin
                n_fail++; $display("FAIL legal_err_%0d got dv=%b err=%b want 1/%b", i, tl_o.d_valid, tl_o.d_error, !legal[i]);
            end
            d_handshake();
        end
        reg_rsp = '0;
    endtask

    task automatic test_reg_error();
        reg_rsp.ready = 1'b1;
        reg_rsp.error = 1'b1;
        drive_a(3'd0, 32'h8, 2'd2, 4'hF, 32'h55, 8'h11);
        n_cmp++; if ({reg_req.valid, reg_req.write, reg_req.wstrb} !== {1'b1, 1'b1, 4'hF}) begin
            n_fail++; $display("FAIL rerr_req got v=%b w=%b s=%h want 1/1/f", reg_req.valid, reg_req.write, reg_req.wstrb);
        end
        tick();
        reg_rsp = '0;
        n_cmp++; if ({tl_o.d_valid, tl_o.d_error, tl_o.d_opcode} !== {1'b1, 1'b1, 3'd0}) begin
            n_fail++; $display("FAIL rerr_d got dv=%b err=%b op=%h want 1/1/0", tl_o.d_valid, tl_o.d_error, tl_o.d_opcode);
        end
        d_handshake();
    endtask

    task automatic test_back_to_back();
        reg_rsp.ready = 1'b1;
        reg_rsp.rdata = 32'hCAFE0001;
        drive_a(3'd4, 32'h20, 2'd2, 4'hF, 32'h0, 8'h09);
        tick();
        reg_rsp = '0;
        tl_i.a_valid   = 1'b1;
        tl_i.a_opcode  = 3'd4;
        tl_i.a_address = 32'h24;
        tl_i.a_source  = 8'h0A;
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if ({tl_o.d_valid, tl_o.d_data, tl_o.d_source, tl_o.a_ready} !== {1'b1, 32'hCAFE0001, 8'h09, 1'b0}) begin
                n_fail++; $display("FAIL stall_%0d got dv=%b data=%h src=%h ar=%b want 1/cafe0001/09/0",
                                   i, tl_o.d_valid, tl_o.d_data, tl_o.d_source, tl_o.a_ready);
            end
            tick();
        end
        tl_i.d_ready = 1'b1;
        tick();
        tl_i.d_ready = 1'b0;
        n_cmp++; if ({tl_o.a_ready, tl_o.d_valid, reg_req.valid} !== 3'b100) begin
            n_fail++; $display("FAIL b2b_idle got ar=%b dv=%b rv=%b want 1/0/0", tl_o.a_ready, tl_o.d_valid, reg_req.valid);
        end
        reg_rsp.ready = 1'b1;
        reg_rsp.rdata = 32'hCAFE0002;
        tick();
        tl_i.a_valid = 1'b0;
        n_cmp++; if ({reg_req.valid, reg_req.addr} !== {1'b1, 32'h24}) begin
            n_fail++; $display("FAIL b2b_req got v=%b a=%h want 1/24", reg_req.valid, reg_req.addr);
        end
        tick();
        reg_rsp = '0;
        n_cmp++; if ({tl_o.d_valid, tl_o.d_data, tl_o.d_source} !== {1'b1, 32'hCAFE0002, 8'h0A}) begin
            n_fail++; $display("FAIL b2b_rsp got dv=%b data=%h src=%h want 1/cafe0002/0a", tl_o.d_valid, tl_o.d_data, tl_o.d_source);
        end
        d_handshake();
    endtask

    task automatic test_reset_in_req();
        reg_rsp = '0;
        drive_a(3'd4, 32'h30, 2'd2, 4'hF, 32'h0, 8'h01);
        n_cmp++; if (reg_req.valid !== 1'b1) begin n_fail++; $display("FAIL rreq_pre got %b want 1", reg_req.valid); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({reg_req.valid, tl_o.d_valid, tl_o.a_ready} !== 3'b001) begin
            n_fail++; $display("FAIL rreq_abort got rv=%b dv=%b ar=%b want 0/0/1", reg_req.valid, tl_o.d_valid, tl_o.a_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        reg_rsp.ready = 1'b1;
        reg_rsp.rdata = 32'h600DF00D;
        drive_a(3'd4, 32'h34, 2'd2, 4'hF, 32'h0, 8'h02);
        n_cmp++; if ({reg_req.valid, reg_req.addr} !== {1'b1, 32'h34}) begin
            n_fail++; $display("FAIL rreq_new_req got v=%b a=%h want 1/34", reg_req.valid, reg_req.addr);
        end
        tick();
        reg_rsp = '0;
        n_cmp++; if ({tl_o.d_valid, tl_o.d_data, tl_o.d_error} !== {1'b1, 32'h600DF00D, 1'b0}) begin
            n_fail++; $display("FAIL rreq_new_rsp got dv=%b data=%h err=%b want 1/600df00d/0", tl_o.d_valid, tl_o.d_data, tl_o.d_error);
        end
        d_handshake();
    endtask

    initial begin
        test_reset();
        test_get();
        test_put_partial();
        test_misaligned();
        test_legality();
        test_reg_error();
        test_back_to_back();
        test_reset_in_req();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
